// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory protocol onto one shared slave.
// Optional slave watchdog enabled by defining MEM_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 1..65535");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_last;
  logic   w_owner_nxt;
  logic   w_last_nxt;
  logic   w_own_valid;
  logic   w_done;
  logic   w_expire;

  assign w_own_valid = r_owner ? m1_valid : m0_valid;
  // Completion needs the owner still requesting; a dropped valid is an abort even if s_ready is high.
  assign w_done      = (r_state == BUSY) && w_own_valid && s_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (!s_ready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_expire = (r_state == BUSY) && w_own_valid && !s_ready && (r_cnt == 16'(TIMEOUT));
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = s_rdata;
    m1_rdata    = s_rdata;
    grant       = '0;
    timeout_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          w_state_nxt = BUSY;
          w_owner_nxt = (m0_valid && m1_valid) ? ~r_last : m1_valid;
        end
      end
      BUSY: begin
        grant   = r_owner ? 2'b10 : 2'b01;
        s_valid = w_own_valid && !w_expire;
        s_addr  = r_owner ? m1_addr  : m0_addr;
        s_wdata = r_owner ? m1_wdata : m0_wdata;
        s_wstrb = r_owner ? m1_wstrb : m0_wstrb;
        if (w_done || w_expire) begin
          m0_ready    = !r_owner;
          m1_ready    = r_owner;
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else if (!w_own_valid) begin
          w_state_nxt = IDLE;
        end
        if (w_expire) begin
          timeout_err = 1'b1;
          m0_rdata    = '0;
          m1_rdata    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
